// File: rtl/md5_pkg.sv
// md5_pkg: shared FSM encoding, default address map, size codes and buffer word counts
package md5_pkg;
  typedef enum logic [2:0] {S_IDLE, S_START, S_RUN, S_DONE, S_ERR} state_t;
  localparam logic [31:0] MSG_BASE_DEF = 32'h4000_0000;
  localparam logic [31:0] LEN_BASE_DEF = 32'h4000_0100;
  localparam logic [31:0] DIGEST_BASE_DEF = 32'h4000_0200;
  localparam logic [5:0] SZ_8 = 6'd8;
  localparam logic [5:0] SZ_32 = 6'd32;
  localparam int MSG_WORDS = 16;
  localparam int DIG_WORDS = 4;
endpackage

// File: rtl/md5_mem_port.sv
// md5_mem_port: one core memory channel - address decode, size/lane check, write request and 1-cycle response
module md5_mem_port
  import md5_pkg::*;
#(
  parameter logic [31:0] MSG_BASE = MSG_BASE_DEF,
  parameter logic [31:0] LEN_BASE = LEN_BASE_DEF,
  parameter logic [31:0] DIGEST_BASE = DIGEST_BASE_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       oe,
  input  logic                       we,
  input  logic [31:0]                addr,
  input  logic [31:0]                wdata,
  input  logic [5:0]                 size,
  input  logic [32*MSG_WORDS-1:0]    msg,
  input  logic [6:0]                 len,
  input  logic [32*DIG_WORDS-1:0]    dig,
  output logic                       wr_msg,
  output logic                       wr_dig,
  output logic [3:0]                 widx,
  output logic [3:0]                 wbe,
  output logic [31:0]                wval,
  output logic                       err,
  output logic [31:0]                rdata_q,
  output logic                       rdy_q
);
  logic [31:0] moff, doff, word, rd, rdata_d;
  logic in_msg, in_len, in_dig, sz_ok, ok, acc, rdy_d;
  always_comb begin
    moff = addr - MSG_BASE;
    doff = addr - DIGEST_BASE;
    in_msg = moff < 32'd64;
    in_dig = doff < 32'd16;
    in_len = addr[31:2] == LEN_BASE[31:2];
    sz_ok = (size == SZ_32 && addr[1:0] == 2'd0) || size == SZ_8;
    acc = oe | we;
    ok = sz_ok && (in_msg || in_len || in_dig);
    err = acc && !ok;
    widx = in_msg ? moff[5:2] : {2'b00, doff[3:2]};
    word = in_msg ? msg[32*widx +: 32] : in_dig ? dig[32*widx[1:0] +: 32] : {25'd0, len};
    rd = size == SZ_8 ? {24'd0, word[8*addr[1:0] +: 8]} : word;
    // byte writes take the low data byte and steer it to lane addr[1:0]
    wbe = size == SZ_8 ? 4'b0001 << addr[1:0] : 4'hf;
    wval = size == SZ_8 ? {4{wdata[7:0]}} : wdata;
    wr_msg = we && ok && in_msg;
    wr_dig = we && ok && in_dig;
    rdata_d = (oe && !we && ok) ? rd : 32'd0;
    rdy_d = acc;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rdata_q <= 32'd0;
      rdy_q <= 1'b0;
    end else begin
      rdata_q <= rdata_d;
      rdy_q <= rdy_d;
    end
endmodule

// File: rtl/md5_mem_responder.sv
// md5_mem_responder: host job sequencer and shared memory model serving an MD5 core over two channels
module md5_mem_responder
  import md5_pkg::*;
#(
  parameter logic [31:0] MSG_BASE = MSG_BASE_DEF,
  parameter logic [31:0] LEN_BASE = LEN_BASE_DEF,
  parameter logic [31:0] DIGEST_BASE = DIGEST_BASE_DEF,
  parameter int unsigned TIMEOUT = 4096
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         msg_we,
  input  logic [3:0]   msg_addr,
  input  logic [31:0]  msg_wdata,
  input  logic [6:0]   msg_len,
  input  logic         job_start,
  output logic         job_done,
  output logic         job_err,
  output logic [127:0] digest,
  output logic         digest_valid,
  output logic         core_start,
  input  logic         core_done,
  input  logic [1:0]   Mout_oe_ram,
  input  logic [1:0]   Mout_we_ram,
  input  logic [63:0]  Mout_addr_ram,
  input  logic [63:0]  Mout_Wdata_ram,
  input  logic [11:0]  Mout_data_ram_size,
  output logic [63:0]  M_Rdata_ram,
  output logic [1:0]   M_DataRdy
);
  state_t state_q, state_d;
  logic [31:0] wdog_q, wdog_d;
  logic [6:0] len_q, len_d;
  logic [32*MSG_WORDS-1:0] msg_q, msg_d;
  logic [32*DIG_WORDS-1:0] dig_q, dig_d;
  logic start_q, start_d, done_q, done_d, err_q, err_d, valid_q, valid_d;
  logic [1:0] wr_msg, wr_dig, perr, rdy;
  logic [3:0] widx [2];
  logic [3:0] wbe [2];
  logic [31:0] wval [2];
  logic [31:0] rdata [2];
  for (genvar c = 0; c < 2; c++) begin : g_port
    md5_mem_port #(.MSG_BASE(MSG_BASE), .LEN_BASE(LEN_BASE), .DIGEST_BASE(DIGEST_BASE)) u_port (
      .clk(clk), .rst_n(rst_n),
      .oe(Mout_oe_ram[c]), .we(Mout_we_ram[c]),
      .addr(Mout_addr_ram[32*c +: 32]), .wdata(Mout_Wdata_ram[32*c +: 32]),
      .size(Mout_data_ram_size[6*c +: 6]),
      .msg(msg_q), .len(len_q), .dig(dig_q),
      .wr_msg(wr_msg[c]), .wr_dig(wr_dig[c]), .widx(widx[c]), .wbe(wbe[c]), .wval(wval[c]),
      .err(perr[c]), .rdata_q(rdata[c]), .rdy_q(rdy[c])
    );
  end
  always_comb begin
    state_d = state_q;
    wdog_d = wdog_q;
    len_d = len_q;
    msg_d = msg_q;
    dig_d = dig_q;
    start_d = 1'b0;
    done_d = 1'b0;
    err_d = err_q | (|perr);
    valid_d = valid_q;
    if (state_q == S_IDLE && msg_we) msg_d[32*msg_addr +: 32] = msg_wdata;
    // channel 1 is applied last so it wins a same-byte collision
    for (int c = 0; c < 2; c++)
      for (int b = 0; b < 4; b++)
        if (wbe[c][b]) begin
          if (wr_msg[c]) msg_d[32*widx[c] + 8*b +: 8] = wval[c][8*b +: 8];
          if (wr_dig[c]) dig_d[32*widx[c][1:0] + 8*b +: 8] = wval[c][8*b +: 8];
        end
    case (state_q)
      S_IDLE: if (job_start) begin
        state_d = S_START;
        start_d = 1'b1;
        len_d = msg_len;
        valid_d = 1'b0;
        dig_d = '0;
        err_d = |perr;
      end
      S_START: begin
        state_d = S_RUN;
        wdog_d = TIMEOUT;
      end
      S_RUN: begin
        wdog_d = wdog_q - 32'd1;
        if (core_done) begin
          state_d = S_DONE;
          done_d = 1'b1;
          valid_d = 1'b1;
        end else if (wdog_q == 32'd1) begin
          state_d = S_ERR;
          done_d = 1'b1;
          err_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= S_IDLE;
      wdog_q <= 32'd0;
      len_q <= 7'd0;
      msg_q <= '0;
      dig_q <= '0;
      start_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wdog_q <= wdog_d;
      len_q <= len_d;
      msg_q <= msg_d;
      dig_q <= dig_d;
      start_q <= start_d;
      done_q <= done_d;
      err_q <= err_d;
      valid_q <= valid_d;
    end
  assign core_start = start_q;
  assign job_done = done_q;
  assign job_err = err_q;
  assign digest_valid = valid_q;
  assign digest = dig_q;
  assign M_Rdata_ram = {rdata[1], rdata[0]};
  assign M_DataRdy = rdy;
endmodule

// File: tb/tb_md5_mem_responder.sv
// tb_md5_mem_responder: directed scenario tests with hand-computed expectations
module tb_md5_mem_responder;
  localparam logic [31:0] MB = 32'h4000_0000;
  localparam logic [31:0] LB = 32'h4000_0100;
  localparam logic [31:0] DB = 32'h4000_0200;
  localparam logic [127:0] EMPTY_DG = 128'h7e42f8ec_980980e9_04b2008f_d98c1dd4;
  localparam logic [127:0] ABC_DG = 128'h727fe128_7d3f96d6_b04fd23c_98500190;
  logic clk = 1'b0, rst_n = 1'b1, msg_we = 1'b0, job_start = 1'b0, core_done = 1'b0;
  logic [3:0] msg_addr = 4'd0;
  logic [31:0] msg_wdata = 32'd0;
  logic [6:0] msg_len = 7'd0;
  logic job_done, job_err, digest_valid, core_start;
  logic [127:0] digest;
  logic [1:0] oe = 2'b00, we = 2'b00;
  logic [63:0] addr = 64'd0, wdata = 64'd0;
  logic [11:0] size = 12'd0;
  logic [63:0] rdata;
  logic [1:0] rdy;
  logic cs_start, cs_run, dv_start;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  md5_mem_responder #(.TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .msg_we(msg_we), .msg_addr(msg_addr), .msg_wdata(msg_wdata),
    .msg_len(msg_len), .job_start(job_start), .job_done(job_done), .job_err(job_err),
    .digest(digest), .digest_valid(digest_valid), .core_start(core_start), .core_done(core_done),
    .Mout_oe_ram(oe), .Mout_we_ram(we), .Mout_addr_ram(addr), .Mout_Wdata_ram(wdata),
    .Mout_data_ram_size(size), .M_Rdata_ram(rdata), .M_DataRdy(rdy)
  );
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic drv(input int ch, input logic o, input logic w, input logic [31:0] a,
                     input logic [31:0] d, input logic [5:0] sz);
    oe[ch] = o;
    we[ch] = w;
    addr[32*ch +: 32] = a;
    wdata[32*ch +: 32] = d;
    size[6*ch +: 6] = sz;
  endtask
  task automatic clr;
    oe = 2'b00;
    we = 2'b00;
    addr = 64'd0;
    wdata = 64'd0;
    size = 12'd0;
  endtask
  // load message, run one job with a core model that writes dg, stop in the DONE cycle
  task automatic do_job(input logic [31:0] w0, input logic [6:0] len, input logic [127:0] dg);
    msg_we = 1'b1;
    for (int i = 0; i < 16; i++) begin
      msg_addr = i[3:0];
      msg_wdata = (i == 0) ? w0 : 32'd0;
      tick;
    end
    msg_we = 1'b0;
    msg_len = len;
    job_start = 1'b1;
    tick;
    job_start = 1'b0;
    cs_start = core_start;
    dv_start = digest_valid;
    tick;
    cs_run = core_start;
    drv(0, 1'b0, 1'b1, DB, dg[31:0], 6'd32);
    drv(1, 1'b0, 1'b1, DB + 32'd4, dg[63:32], 6'd32);
    tick;
    drv(0, 1'b0, 1'b1, DB + 32'd8, dg[95:64], 6'd32);
    drv(1, 1'b0, 1'b1, DB + 32'd12, dg[127:96], 6'd32);
    tick;
    clr;
    core_done = 1'b1;
    tick;
    core_done = 1'b0;
  endtask
  task automatic test_reset;
    #1 rst_n = 1'b0;
    #1;
    total++; if (job_done !== 1'b0) begin bad++; $display("FAIL reset_job_done got=%b exp=0", job_done); end
    total++; if (job_err !== 1'b0) begin bad++; $display("FAIL reset_job_err got=%b exp=0", job_err); end
    total++; if (digest_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", digest_valid); end
    total++; if (digest !== 128'd0) begin bad++; $display("FAIL reset_digest got=%h exp=0", digest); end
    total++; if (core_start !== 1'b0) begin bad++; $display("FAIL reset_core_start got=%b exp=0", core_start); end
    total++; if ({rdy, rdata} !== 66'd0) begin bad++; $display("FAIL reset_mem_resp got=%h/%h exp=0/0", rdy, rdata); end
    @(negedge clk) rst_n = 1'b1;
    tick;
  endtask
  task automatic test_empty;
    do_job(32'h0000_0080, 7'd0, EMPTY_DG);
    total++; if (cs_start !== 1'b1) begin bad++; $display("FAIL empty_core_start got=%b exp=1", cs_start); end
    total++; if (cs_run !== 1'b0) begin bad++; $display("FAIL empty_core_start_len got=%b exp=0", cs_run); end
    total++; if (job_done !== 1'b1) begin bad++; $display("FAIL empty_done got=%b exp=1", job_done); end
    total++; if (digest_valid !== 1'b1) begin bad++; $display("FAIL empty_valid got=%b exp=1", digest_valid); end
    total++; if (job_err !== 1'b0) begin bad++; $display("FAIL empty_err got=%b exp=0", job_err); end
    total++; if (digest !== EMPTY_DG) begin bad++; $display("FAIL empty_digest got=%h exp=%h", digest, EMPTY_DG); end
    tick;
    total++; if (job_done !== 1'b0) begin bad++; $display("FAIL empty_done_pulse got=%b exp=0", job_done); end
    total++; if (digest_valid !== 1'b1) begin bad++; $display("FAIL empty_valid_hold got=%b exp=1", digest_valid); end
  endtask
  task automatic test_abc;
    do_job(32'h8063_6261, 7'd3, ABC_DG);
    total++; if (dv_start !== 1'b0) begin bad++; $display("FAIL abc_valid_cleared got=%b exp=0", dv_start); end
    total++; if (job_done !== 1'b1) begin bad++; $display("FAIL abc_done got=%b exp=1", job_done); end
    total++; if (digest !== ABC_DG) begin bad++; $display("FAIL abc_digest got=%h exp=%h", digest, ABC_DG); end
    total++; if (job_err !== 1'b0) begin bad++; $display("FAIL abc_err got=%b exp=0", job_err); end
    tick;
  endtask
  task automatic test_dual_read;
    drv(0, 1'b1, 1'b0, MB, 32'd0, 6'd32);
    drv(1, 1'b1, 1'b0, LB, 32'd0, 6'd32);
    tick;
    clr;
    total++; if (rdy !== 2'b11) begin bad++; $display("FAIL dual_rdy got=%b exp=11", rdy); end
    total++; if (rdata !== {32'd3, 32'h8063_6261}) begin bad++; $display("FAIL dual_data got=%h exp=%h", rdata, {32'd3, 32'h8063_6261}); end
    tick;
    total++; if (rdy !== 2'b00) begin bad++; $display("FAIL dual_rdy_once got=%b exp=00", rdy); end
    drv(0, 1'b1, 1'b0, MB + 32'd1, 32'd0, 6'd8);
    drv(1, 1'b1, 1'b0, DB + 32'd3, 32'd0, 6'd8);
    tick;
    clr;
    total++; if (rdata !== {32'h98, 32'h62}) begin bad++; $display("FAIL byte_read got=%h exp=%h", rdata, {32'h98, 32'h62}); end
    tick;
  endtask
  task automatic test_collision;
    drv(0, 1'b0, 1'b1, DB + 32'd1, 32'h0000_00aa, 6'd8);
    drv(1, 1'b0, 1'b1, DB + 32'd1, 32'h0000_00bb, 6'd8);
    tick;
    clr;
    total++; if (digest[31:0] !== 32'h9850_bb90) begin bad++; $display("FAIL collide_byte got=%h exp=9850bb90", digest[31:0]); end
    total++; if (rdy !== 2'b11) begin bad++; $display("FAIL collide_rdy got=%b exp=11", rdy); end
    drv(0, 1'b0, 1'b1, MB + 32'd4, 32'h1122_3344, 6'd32);
    drv(1, 1'b1, 1'b0, MB + 32'd4, 32'd0, 6'd32);
    tick;
    clr;
    total++; if (rdata[63:32] !== 32'd0) begin bad++; $display("FAIL rw_old_data got=%h exp=0", rdata[63:32]); end
    drv(1, 1'b1, 1'b0, MB + 32'd4, 32'd0, 6'd32);
    drv(0, 1'b0, 1'b1, LB, 32'h55, 6'd32);
    tick;
    clr;
    total++; if (rdata[63:32] !== 32'h1122_3344) begin bad++; $display("FAIL rw_new_data got=%h exp=11223344", rdata[63:32]); end
    drv(0, 1'b1, 1'b0, LB, 32'd0, 6'd32);
    tick;
    clr;
    total++; if (rdata[31:0] !== 32'd3) begin bad++; $display("FAIL len_write_ignored got=%h exp=3", rdata[31:0]); end
    total++; if (job_err !== 1'b0) begin bad++; $display("FAIL collide_err got=%b exp=0", job_err); end
    tick;
  endtask
  task automatic test_unmapped;
    drv(0, 1'b1, 1'b0, 32'h4000_0300, 32'd0, 6'd32);
    tick;
    clr;
    total++; if (rdy !== 2'b01) begin bad++; $display("FAIL unmap_rdy got=%b exp=01", rdy); end
    total++; if (rdata[31:0] !== 32'd0) begin bad++; $display("FAIL unmap_data got=%h exp=0", rdata[31:0]); end
    total++; if (job_err !== 1'b1) begin bad++; $display("FAIL unmap_err got=%b exp=1", job_err); end
    tick;
    total++; if (job_err !== 1'b1) begin bad++; $display("FAIL unmap_err_sticky got=%b exp=1", job_err); end
  endtask
  task automatic test_misaligned;
    do_job(32'h0000_0080, 7'd0, EMPTY_DG);
    total++; if (job_err !== 1'b0) begin bad++; $display("FAIL err_cleared got=%b exp=0", job_err); end
    tick;
    drv(1, 1'b1, 1'b0, MB + 32'd2, 32'd0, 6'd32);
    tick;
    clr;
    total++; if (rdy !== 2'b10) begin bad++; $display("FAIL misalign_rdy got=%b exp=10", rdy); end
    total++; if (rdata[63:32] !== 32'd0) begin bad++; $display("FAIL misalign_data got=%h exp=0", rdata[63:32]); end
    total++; if (job_err !== 1'b1) begin bad++; $display("FAIL misalign_err got=%b exp=1", job_err); end
    tick;
  endtask
  task automatic test_core_done_idle;
    core_done = 1'b1;
    tick;
    core_done = 1'b0;
    total++; if (job_done !== 1'b0) begin bad++; $display("FAIL idle_core_done got=%b exp=0", job_done); end
    tick;
  endtask
  task automatic test_timeout;
    int early;
    early = 0;
    job_start = 1'b1;
    tick;
    job_start = 1'b0;
    total++; if (core_start !== 1'b1) begin bad++; $display("FAIL to_core_start got=%b exp=1", core_start); end
    total++; if (job_err !== 1'b0) begin bad++; $display("FAIL to_err_cleared got=%b exp=0", job_err); end
    for (int i = 0; i < 16; i++) begin
      tick;
      if (job_done !== 1'b0) early++;
    end
    total++; if (early !== 0) begin bad++; $display("FAIL to_early_done got=%0d exp=0", early); end
    tick;
    total++; if (job_done !== 1'b1) begin bad++; $display("FAIL to_done got=%b exp=1", job_done); end
    total++; if (job_err !== 1'b1) begin bad++; $display("FAIL to_err got=%b exp=1", job_err); end
    total++; if (digest_valid !== 1'b0) begin bad++; $display("FAIL to_valid got=%b exp=0", digest_valid); end
    tick;
    total++; if (job_done !== 1'b0) begin bad++; $display("FAIL to_done_pulse got=%b exp=0", job_done); end
    total++; if (job_err !== 1'b1) begin bad++; $display("FAIL to_err_sticky got=%b exp=1", job_err); end
  endtask
  task automatic test_reset_mid_run;
    int pulses;
    pulses = 0;
    job_start = 1'b1;
    tick;
    job_start = 1'b0;
    tick;
    drv(0, 1'b1, 1'b0, 32'h4000_0300, 32'd0, 6'd32);
    drv(1, 1'b0, 1'b1, DB, 32'hdead_beef, 6'd32);
    tick;
    clr;
    total++; if ({rdy, job_err, digest[31:0]} !== {2'b11, 1'b1, 32'hdead_beef}) begin
      bad++; $display("FAIL mid_pre got=%b/%b/%h exp=11/1/deadbeef", rdy, job_err, digest[31:0]);
    end
    #2 rst_n = 1'b0;
    #1;
    total++; if ({rdy, rdata} !== 66'd0) begin bad++; $display("FAIL mid_mem_resp got=%h/%h exp=0/0", rdy, rdata); end
    total++; if ({job_err, job_done, digest_valid, core_start} !== 4'd0) begin
      bad++; $display("FAIL mid_ctrl got=%b exp=0000", {job_err, job_done, digest_valid, core_start});
    end
    total++; if (digest !== 128'd0) begin bad++; $display("FAIL mid_digest got=%h exp=0", digest); end
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick;
      if (job_done !== 1'b0) pulses++;
    end
    total++; if (pulses !== 0) begin bad++; $display("FAIL mid_no_done got=%0d exp=0", pulses); end
    do_job(32'h8063_6261, 7'd3, ABC_DG);
    total++; if (job_done !== 1'b1) begin bad++; $display("FAIL post_done got=%b exp=1", job_done); end
    total++; if (digest !== ABC_DG) begin bad++; $display("FAIL post_digest got=%h exp=%h", digest, ABC_DG); end
    total++; if (digest_valid !== 1'b1) begin bad++; $display("FAIL post_valid got=%b exp=1", digest_valid); end
    tick;
  endtask
  initial begin
    test_reset;
    test_empty;
    test_abc;
    test_dual_read;
    test_collision;
    test_unmapped;
    test_misaligned;
    test_core_done_idle;
    test_timeout;
    test_reset_mid_run;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/md5_mem_responder.md
MD5_MEM_RESPONDER -- requirements
Module: md5_mem_responder

Interface
REQ-001 Parameter MSG_BASE, 32'h40000000, byte address of 64-byte message buffer (16 words).
REQ-002 Parameter LEN_BASE, 32'h40000100, byte address of 32-bit message-length word.
REQ-003 Parameter DIGEST_BASE, 32'h40000200, byte address of 16-byte digest buffer (4 words).
REQ-004 Parameter TIMEOUT, 4096, max cycles from core_start to core_done.
REQ-005 Ports SHALL be: clk in 1 clock; reset in 1 asynchronous active-low reset; one clock, no other clock domains.
REQ-006 Host: msg_we in 1; msg_addr in 4 word index; msg_wdata in 32; msg_len in 7 byte count 0..55; job_start in 1 pulse; job_done out 1 pulse; job_err out 1 sticky; digest out 128; digest_valid out 1.
REQ-007 Core control: core_start out 1 (to start_port); core_done in 1 (from done_port).
REQ-008 Core memory, channel ch in {0,1} at bits [32*ch+31:32*ch] (size [6*ch+5:6*ch]): Mout_oe_ram in 2; Mout_we_ram in 2; Mout_addr_ram in 64; Mout_Wdata_ram in 64; Mout_data_ram_size in 12 (bits); M_Rdata_ram out 64; M_DataRdy out 2.

Function
REQ-009 FSM states IDLE, START, RUN, DONE, ERR; reset state IDLE.
REQ-010 IDLE: job_start -> START, clearing digest_valid and the digest buffer; msg_we writes message word msg_addr; msg_len is sampled into the length register at job_start.
REQ-011 START: core_start=1 for exactly one cycle, then RUN; watchdog loaded with TIMEOUT.
REQ-012 RUN: core_done=1 -> DONE; watchdog reaching 0 first -> ERR, job_err=1.
REQ-013 DONE: job_done=1 and digest_valid=1 for one cycle, then IDLE; digest_valid then stays 1 until next job_start.
REQ-014 ERR: job_done=1 for one cycle, then IDLE; job_err stays 1 until next job_start.
REQ-015 Reads: oe[ch] in cycle N -> M_DataRdy[ch]=1 and M_Rdata_ram channel slice valid in cycle N+1 only; fixed latency 1.
REQ-016 Writes: we[ch] in cycle N -> storage updated at end of N, M_DataRdy[ch]=1 in cycle N+1.
REQ-017 Sizes: 32 (word-aligned) and 8 (any byte, lane = addr[1:0], little-endian, read zero-extended); other sizes or misaligned words -> no storage change, read data 0, job_err=1, DataRdy still given.
REQ-018 Map: message readable anywhere, writable by core; LEN_BASE read returns zero-extended length, writes ignored; digest readable and writable.
REQ-019 Unmapped address: read returns 0, write ignored, job_err=1, DataRdy still given.
REQ-020 Both channels writing the same byte in one cycle: channel 1 wins.
REQ-021 Same-cycle core write and read to one address: read returns old data.
REQ-022 msg_we outside IDLE ignored; job_start outside IDLE ignored; core_done outside RUN ignored.
REQ-023 Core accesses accepted in every state; oe and we both set on one channel treated as write.
REQ-024 digest[31:0]=digest word 0 (DIGEST_BASE), ... digest[127:96]=word 3.

Reset
REQ-025 Reset low SHALL asynchronously force IDLE; M_Rdata_ram, M_DataRdy, core_start, job_done, job_err, digest_valid, watchdog, length, message and digest buffers to 0.
REQ-026 Reset mid-RUN SHALL abandon the job with no job_done pulse; outputs leave reset value only after release, on clk.

Structure
REQ-027 Shared package md5_pkg SHALL hold the FSM state encoding, default base addresses, size codes (8, 32) and word counts (16, 4).
REQ-028 One sub-module md5_mem_port, instantiated per channel, SHALL perform address decode, size/lane check and response register.

Verification
REQ-029 msg_len=0, word0=32'h00000080, rest 0; job_start; core returns -> digest=128'h7e42f8ec_980980e9_04b2008f_d98c1dd4, digest_valid=1, job_err=0.
REQ-030 Message "abc" (word0=32'h80636261, len 3) -> digest word0..3 = 98500190, b04fd23c, 7d3f96d6, 727fe128.
REQ-031 Core-model reads on both channels same cycle at MSG_BASE and LEN_BASE -> next cycle M_DataRdy=2'b11, correct slices.
REQ-032 core_done withheld, TIMEOUT=16 -> ERR after 16 RUN cycles, job_done pulse, job_err=1, digest_valid=0.
REQ-033 Read 32'h40000300 and 32-bit read at MSG_BASE+2 -> data 0, DataRdy=1, job_err=1.
REQ-034 Reset asserted in RUN -> all outputs 0 immediately; after release a new job_start completes normally.
